// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared opcodes, immediate-format codes and controller states.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] IMM_I    = 2'd0;
    localparam logic [1:0] IMM_S    = 2'd1;
    localparam logic [1:0] IMM_B    = 2'd2;
    localparam logic [1:0] IMM_NONE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_STALL    = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_e;

    function automatic logic [1:0] imm_type_of(input logic [6:0] opcode);
        logic [1:0] imm;
        case (opcode)
            OP_STORE:                   imm = IMM_S;
            OP_BRANCH:                  imm = IMM_B;
            OP_IALU, OP_LOAD, OP_JALR:  imm = IMM_I;
            default:                    imm = IMM_NONE;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Control/status bundle between the pipeline and its controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;

    logic        start_i;
    logic [31:0] id_instr_i;
    logic        ex_memread_i;
    logic        ex_regwrite_i;
    logic [4:0]  ex_rd_i;
    logic        branch_taken_i;
    logic        dmem_req_i;
    logic        dmem_ack_i;
    logic [1:0]  imm_type_o;
    logic        pc_write_o;
    logic        pc_src_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        freeze_o;
    logic        err_o;

    modport master (
        input  start_i, id_instr_i, ex_memread_i, ex_regwrite_i, ex_rd_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        output imm_type_o, pc_write_o, pc_src_o, ifid_write_o, ifid_flush_o,
               idex_bubble_o, freeze_o, err_o
    );

    modport slave (
        output start_i, id_instr_i, ex_memread_i, ex_regwrite_i, ex_rd_i,
               branch_taken_i, dmem_req_i, dmem_ack_i,
        input  imm_type_o, pc_write_o, pc_src_o, ifid_write_o, ifid_flush_o,
               idex_bubble_o, freeze_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational load-use / branch-operand hazard detection at ID.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [31:0] id_instr_i,
    input  logic        ex_memread_i,
    input  logic        ex_regwrite_i,
    input  logic [4:0]  ex_rd_i,
    output logic        load_use_o,
    output logic        branch_alu_o
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_is_branch;
    logic       w_match;
    logic       w_unused;

    assign w_opcode    = id_instr_i[6:0];
    assign w_rs1       = id_instr_i[19:15];
    assign w_rs2       = id_instr_i[24:20];
    assign w_is_branch = (w_opcode == OP_BRANCH);

    assign w_use_rs2 = (w_opcode == OP_R) || (w_opcode == OP_STORE) || w_is_branch;
    assign w_use_rs1 = w_use_rs2 || (w_opcode == OP_IALU) ||
                       (w_opcode == OP_LOAD) || (w_opcode == OP_JALR);

    // x0 is never a real producer, so it can never cause a hazard
    assign w_match = (ex_rd_i != 5'd0) &&
                     ((w_use_rs1 && (w_rs1 == ex_rd_i)) ||
                      (w_use_rs2 && (w_rs2 == ex_rd_i)));

    assign load_use_o   = ex_memread_i && w_match;
    assign branch_alu_o = w_is_branch && ex_regwrite_i && !ex_memread_i && w_match;

    assign w_unused = &{1'b0, id_instr_i[31:25], id_instr_i[14:7]};

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Sequencing/hazard controller: stalls, branch flush, memory freeze.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipeline_ctrl_if.master  bus
);

    localparam logic [CNT_W:0] TIMEOUT_L          = (CNT_W+1)'(MEM_TIMEOUT);
    localparam bit             FIRST_WAIT_TIMEOUT = (MEM_TIMEOUT <= 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic             w_load_use;
    logic             w_branch_alu;
    logic             w_id_is_branch;
    logic             w_mem_stall;
    logic [CNT_W:0]   w_wait_inc;
    logic             w_pc_write;
    logic             w_pc_src;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_bubble;
    logic             w_freeze;

    hazard_detect u_hazard_detect (
        .id_instr_i    (bus.id_instr_i),
        .ex_memread_i  (bus.ex_memread_i),
        .ex_regwrite_i (bus.ex_regwrite_i),
        .ex_rd_i       (bus.ex_rd_i),
        .load_use_o    (w_load_use),
        .branch_alu_o  (w_branch_alu)
    );

    assign w_id_is_branch = (bus.id_instr_i[6:0] == OP_BRANCH);
    assign w_mem_stall    = bus.dmem_req_i && !bus.dmem_ack_i;
    assign w_wait_inc     = {1'b0, wait_cnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        err_d         = err_q;
        w_pc_write    = 1'b0;
        w_pc_src      = 1'b0;
        w_ifid_write  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_freeze      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_RUN;
            end

            S_RUN: begin
                if (w_mem_stall) begin
                    w_freeze   = 1'b1;
                    wait_cnt_d = CNT_W'(1);
                    if (FIRST_WAIT_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_MEM_WAIT;
                    end
                end else if (w_load_use || w_branch_alu) begin
                    w_idex_bubble = 1'b1;
                    // a branch consuming a load needs a second bubble
                    if (w_load_use && w_id_is_branch) begin
                        stall_cnt_d = 2'd1;
                        state_d     = S_STALL;
                    end
                end else if (w_id_is_branch && bus.branch_taken_i) begin
                    w_pc_src     = 1'b1;
                    w_pc_write   = 1'b1;
                    w_ifid_flush = 1'b1;
                end else begin
                    w_pc_write   = 1'b1;
                    w_ifid_write = 1'b1;
                end
            end

            S_STALL: begin
                if (w_mem_stall) begin
                    // stall_cnt_q is kept so we resume the stall after the ack
                    w_freeze   = 1'b1;
                    wait_cnt_d = CNT_W'(1);
                    if (FIRST_WAIT_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_MEM_WAIT;
                    end
                end else begin
                    w_idex_bubble = 1'b1;
                    if (stall_cnt_q <= 2'd1) begin
                        stall_cnt_d = 2'd0;
                        state_d     = S_RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 2'd1;
                    end
                end
            end

            S_MEM_WAIT: begin
                w_freeze = 1'b1;
                if (bus.dmem_ack_i) begin
                    wait_cnt_d = '0;
                    state_d    = (stall_cnt_q != 2'd0) ? S_STALL : S_RUN;
                end else begin
                    wait_cnt_d = w_wait_inc[CNT_W-1:0];
                    if (w_wait_inc >= TIMEOUT_L) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end

            S_HALT: begin
                w_freeze = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imm_type_o    = imm_type_of(bus.id_instr_i[6:0]);
    assign bus.pc_write_o    = w_pc_write;
    assign bus.pc_src_o      = w_pc_src;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign bus.freeze_o      = w_freeze;
    assign bus.err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed scenarios plus random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int TO = 4;

    localparam logic [31:0] SW_INS   = 32'h00A12223;
    localparam logic [31:0] ADD_INS  = 32'h00728333;   // add x6,x5,x7
    localparam logic [31:0] BEQ5_INS = 32'h00028063;   // beq x5,x0
    localparam logic [31:0] BEQ12    = 32'h00208063;   // beq x1,x2
    localparam logic [31:0] NOP_INS  = 32'h00000013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if ifc ();

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // reference model: started / halted / memory pending / owed extra bubbles
    bit         m_started, m_halted, m_waiting, m_err;
    int         m_owed, m_waited;
    logic [8:0] exp_vec;
    wire  [8:0] obs_vec;

    assign obs_vec = {ifc.imm_type_o, ifc.pc_write_o, ifc.pc_src_o, ifc.ifid_write_o,
                      ifc.ifid_flush_o, ifc.idex_bubble_o, ifc.freeze_o, ifc.err_o};

    function automatic logic [1:0] ref_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h23:               return 2'd1;
            7'h63:               return 2'd2;
            7'h13, 7'h03, 7'h67: return 2'd0;
            default:             return 2'd3;
        endcase
    endfunction

    // 0 = none, 1 = load-use, 2 = branch waiting on an ALU result
    function automatic int ref_hazard(input logic [31:0] ins, input bit mr, input bit rw,
                                      input logic [4:0] rd);
        logic [4:0] src [2];
        int         nsrc;
        bit         hit;
        src[0] = ins[19:15];
        src[1] = ins[24:20];
        case (ins[6:0])
            7'h33, 7'h23, 7'h63: nsrc = 2;
            7'h13, 7'h03, 7'h67: nsrc = 1;
            default:             nsrc = 0;
        endcase
        hit = 1'b0;
        for (int i = 0; i < nsrc; i++) if (rd != 5'd0 && src[i] == rd) hit = 1'b1;
        if (hit && mr) return 1;
        if (hit && rw && ins[6:0] == 7'h63) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_waiting = 0; m_err = 0;
        m_owed = 0; m_waited = 0;
    endtask

    task automatic model_eval();
        bit pw, ps, iw, fl, bb, fz, br;
        int hz;
        hz = ref_hazard(ifc.id_instr_i, ifc.ex_memread_i, ifc.ex_regwrite_i, ifc.ex_rd_i);
        br = (ifc.id_instr_i[6:0] == 7'h63);
        {pw, ps, iw, fl, bb, fz} = 6'b0;
        if (!m_started) begin
        end else if (m_halted) fz = 1;
        else if (m_waiting || (ifc.dmem_req_i && !ifc.dmem_ack_i)) fz = 1;
        else if (m_owed > 0 || hz != 0) bb = 1;
        else if (br && ifc.branch_taken_i) begin ps = 1; pw = 1; fl = 1; end
        else begin pw = 1; iw = 1; end
        exp_vec = {ref_imm(ifc.id_instr_i), pw, ps, iw, fl, bb, fz, m_err};
    endtask

    task automatic model_advance();
        int hz;
        bit br;
        hz = ref_hazard(ifc.id_instr_i, ifc.ex_memread_i, ifc.ex_regwrite_i, ifc.ex_rd_i);
        br = (ifc.id_instr_i[6:0] == 7'h63);
        if (!m_started) m_started = ifc.start_i;
        else if (m_halted) begin
        end else if (m_waiting) begin
            if (ifc.dmem_ack_i) begin m_waiting = 0; m_waited = 0; end
            else begin
                m_waited++;
                if (m_waited >= TO) begin m_halted = 1; m_err = 1; end
            end
        end else if (ifc.dmem_req_i && !ifc.dmem_ack_i) begin
            m_waited = 1;
            if (m_waited >= TO) begin m_halted = 1; m_err = 1; end
            else m_waiting = 1;
        end else if (m_owed > 0) m_owed--;
        else if (hz == 1 && br) m_owed = 1;
    endtask

    task automatic drive(input bit st, input logic [31:0] ins, input bit mr, input bit rw,
                         input logic [4:0] rd, input bit tk, input bit rq, input bit ak);
        ifc.start_i = st;        ifc.id_instr_i = ins;
        ifc.ex_memread_i = mr;   ifc.ex_regwrite_i = rw;
        ifc.ex_rd_i = rd;        ifc.branch_taken_i = tk;
        ifc.dmem_req_i = rq;     ifc.dmem_ack_i = ak;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(0, SW_INS, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk); model_eval();
        vectors++;
        if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_model: got %b want %b", obs_vec, exp_vec); end
        vectors++;
        if (obs_vec !== 9'b01_0000000) begin miscompares++; $display("FAIL reset_outputs: got %b want %b", obs_vec, 9'b01_0000000); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.start_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL start_seq c%0d: got %b want %b", c, obs_vec, exp_vec); end
            vectors++;
            if (c == 0) begin
                if ({ifc.pc_write_o, ifc.ifid_write_o} !== 2'b00) begin miscompares++; $display("FAIL idle_enables: got %b want 00", {ifc.pc_write_o, ifc.ifid_write_o}); end
            end else begin
                if ({ifc.pc_write_o, ifc.ifid_write_o, ifc.imm_type_o} !== 4'b1101) begin miscompares++; $display("FAIL run_enables c%0d: got %b want 1101", c, {ifc.pc_write_o, ifc.ifid_write_o, ifc.imm_type_o}); end
            end
            tick();
        end
        ifc.start_i = 1'b0;
    endtask

    task automatic test_load_use();
        logic [2:0] want [3] = '{3'b001, 3'b110, 3'b110};
        for (int c = 0; c < 3; c++) begin
            drive(0, ADD_INS, c != 1, c != 1, (c == 0) ? 5'd5 : 5'd0, 0, 0, 0);
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL load_use c%0d: got %b want %b", c, obs_vec, exp_vec); end
            vectors++;
            if ({ifc.pc_write_o, ifc.ifid_write_o, ifc.idex_bubble_o} !== want[c]) begin miscompares++; $display("FAIL load_use_ctl c%0d: got %b want %b", c, {ifc.pc_write_o, ifc.ifid_write_o, ifc.idex_bubble_o}, want[c]); end
            tick();
        end
    endtask

    task automatic test_branch_stall();
        logic [3:0] bub = '0, flu = '0, src = '0;
        for (int c = 0; c < 4; c++) begin
            drive(0, (c < 3) ? BEQ5_INS : NOP_INS, c == 0, c == 0, (c == 0) ? 5'd5 : 5'd0, c < 3, 0, 0);
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL branch_stall c%0d: got %b want %b", c, obs_vec, exp_vec); end
            bub[c] = ifc.idex_bubble_o; flu[c] = ifc.ifid_flush_o; src[c] = ifc.pc_src_o;
            tick();
        end
        vectors++;
        if ({bub, flu, src} !== 12'b0011_0100_0100) begin miscompares++; $display("FAIL branch_stall_masks: got %b want %b", {bub, flu, src}, 12'b0011_0100_0100); end
    endtask

    task automatic test_mem_wait();
        logic [3:0] frz = '0, flu = '0;
        for (int c = 0; c < 4; c++) begin
            drive(0, BEQ12, 0, 0, 5'd0, 1, c < 3, c == 2);
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL mem_wait c%0d: got %b want %b", c, obs_vec, exp_vec); end
            frz[c] = ifc.freeze_o; flu[c] = ifc.ifid_flush_o;
            tick();
        end
        vectors++;
        if ({frz, flu} !== 8'b0111_1000) begin miscompares++; $display("FAIL mem_wait_masks: got %b want %b", {frz, flu}, 8'b0111_1000); end
    endtask

    task automatic test_stall_mem();
        logic [4:0] bub = '0, frz = '0, flu = '0;
        for (int c = 0; c < 5; c++) begin
            drive(0, BEQ5_INS, c == 0, c == 0, (c == 0) ? 5'd5 : 5'd0, 1, (c == 1) || (c == 2), c == 2);
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL stall_mem c%0d: got %b want %b", c, obs_vec, exp_vec); end
            bub[c] = ifc.idex_bubble_o; frz[c] = ifc.freeze_o; flu[c] = ifc.ifid_flush_o;
            tick();
        end
        vectors++;
        if ({bub, frz, flu} !== 15'b01001_00110_10000) begin miscompares++; $display("FAIL stall_mem_masks: got %b want %b", {bub, frz, flu}, 15'b01001_00110_10000); end
    endtask

    task automatic test_timeout();
        logic [5:0] err = '0, frz = '0;
        for (int c = 0; c < 6; c++) begin
            drive(0, NOP_INS, 0, 0, 5'd0, 0, 1, 0);
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL timeout c%0d: got %b want %b", c, obs_vec, exp_vec); end
            err[c] = ifc.err_o; frz[c] = ifc.freeze_o;
            tick();
        end
        vectors++;
        if ({err, frz} !== 12'b110000_111111) begin miscompares++; $display("FAIL timeout_masks: got %b want %b", {err, frz}, 12'b110000_111111); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({ifc.err_o, ifc.freeze_o} !== 2'b00) begin miscompares++; $display("FAIL async_reset_clear: got %b want 00", {ifc.err_o, ifc.freeze_o}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, NOP_INS, 0, 0, 5'd0, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL restart c%0d: got %b want %b", c, obs_vec, exp_vec); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37};
        logic [31:0] ins;
        for (int n = 0; n < 400; n++) begin
            if ((m_halted && $urandom_range(0, 2) == 0) || $urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                model_reset();
                @(negedge clk); model_eval();
                vectors++;
                if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL random_reset n%0d: got %b want %b", n, obs_vec, exp_vec); end
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 7)];
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 3) == 0, ins, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  5'($urandom_range(0, 3)), $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 0);
            @(negedge clk); model_eval();
            vectors++;
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL random n%0d ins=%h: got %b want %b", n, ins, obs_vec, exp_vec); end
            tick();
        end
    endtask

    initial begin
        drive(0, NOP_INS, 0, 0, 5'd0, 0, 0, 0);
        model_reset();
        test_reset();
        test_load_use();
        test_branch_stall();
        test_mem_wait();
        test_stall_mem();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
